// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART ALU byte controller.
//   - default data/opcode widths
//   - opcode encodings recognised by the ALU
//   - controller state encoding
package uart_alu_interface_pkg;

    localparam int unsigned NBIT_DATA_DEF = 8;
    localparam int unsigned NBIT_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_e;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// Combinational 8-bit ALU used by the UART controller.
// Ports:
//   a, b  in  NBIT_DATA  operands
//   op    in  NBIT_OP    opcode
//   out   out NBIT_DATA  result, truncated; unknown opcodes give zero
module alu
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned NBIT_DATA = NBIT_DATA_DEF,
    parameter int unsigned NBIT_OP   = NBIT_OP_DEF
) (
    input  logic [NBIT_DATA-1:0] a,
    input  logic [NBIT_DATA-1:0] b,
    input  logic [NBIT_OP-1:0]   op,
    output logic [NBIT_DATA-1:0] out
);

    always_comb begin
        out = '0;
        case (op)
            NBIT_OP'(OP_ADD): out = a + b;
            NBIT_OP'(OP_SUB): out = a - b;
            NBIT_OP'(OP_AND): out = a & b;
            NBIT_OP'(OP_OR):  out = a | b;
            NBIT_OP'(OP_XOR): out = a ^ b;
            NBIT_OP'(OP_NOR): out = ~(a | b);
            // Shift amounts at or beyond the width saturate to sign fill / zero.
            NBIT_OP'(OP_SRA): out = NBIT_DATA'($signed(a) >>> b);
            NBIT_OP'(OP_SRL): out = a >> b;
            default:          out = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Byte controller between UART RX and TX: gathers operand A, operand B and
// an opcode, computes the ALU result, launches one transmission and waits
// for it to complete before accepting the next operand set.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   rx_done_tick  receiver byte-complete flag (rising edge = new byte)
//   rx_data       received byte
//   tx_done_tick  transmitter frame-complete flag (rising edge = done)
//   tx_start      one-cycle transmit launch strobe
//   tx_data       byte to transmit
//   result        last computed result
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned NBIT_DATA = NBIT_DATA_DEF,
    parameter int unsigned NBIT_OP   = NBIT_OP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 tx_done_tick,
    output logic                 tx_start,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic [NBIT_DATA-1:0] result
);

    state_e               state_q;
    logic [NBIT_DATA-1:0] a_q;
    logic [NBIT_DATA-1:0] b_q;
    logic [NBIT_OP-1:0]   op_q;
    logic [NBIT_DATA-1:0] tx_data_q;
    logic [NBIT_DATA-1:0] result_q;
    logic                 tx_start_q;
    logic                 rx_d_q;
    logic                 tx_d_q;
    logic                 rx_evt;
    logic                 tx_evt;
    logic [NBIT_DATA-1:0] alu_out;

    // Rising-edge detection so held flags deliver exactly one event.
    assign rx_evt = rx_done_tick & ~rx_d_q;
    assign tx_evt = tx_done_tick & ~tx_d_q;

    alu #(
        .NBIT_DATA (NBIT_DATA),
        .NBIT_OP   (NBIT_OP)
    ) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .out (alu_out)
    );

    // Controller FSM with edge-detect registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            result_q   <= '0;
            tx_start_q <= 1'b0;
            rx_d_q     <= 1'b0;
            tx_d_q     <= 1'b0;
        end else begin
            rx_d_q <= rx_done_tick;
            tx_d_q <= tx_done_tick;
            case (state_q)
                ST_WAIT_A: begin
                    if (rx_evt) begin
                        a_q     <= rx_data;
                        state_q <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (rx_evt) begin
                        b_q     <= rx_data;
                        state_q <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (rx_evt) begin
                        op_q    <= rx_data[NBIT_OP-1:0];
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_data_q  <= alu_out;
                    result_q   <= alu_out;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    tx_start_q <= 1'b0;
                    if (tx_evt) begin
                        state_q <= ST_WAIT_A;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign result   = result_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed cases plus randomized
// operand sets compared against an arithmetic reference model.
module tb_uart_alu_interface;

    logic       clk          = 1'b0;
    logic       reset        = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data      = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    uart_alu_interface #(
        .NBIT_DATA (8),
        .NBIT_OP   (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Count clock periods in which the transmit strobe is high.
    always @(negedge clk) begin
        if (tx_start === 1'b1) pulses++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference ALU: plain integer arithmetic on byte values.
    function automatic int alu_ref(input int a, input int b, input int op_byte);
        int op;
        int sa;
        int sh;
        op = op_byte % 64;
        sh = (b > 31) ? 31 : b;
        case (op)
            32: return (a + b) % 256;
            34: return (a - b + 256) % 256;
            36: return a & b;
            37: return a | b;
            38: return a ^ b;
            39: return 255 - (a | b);
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                // floor division by 2^b, with saturation for large shifts
                if (b >= 8) return (sa < 0) ? 255 : 0;
                sa = (sa >= 0) ? sa / (1 << sh) : -((-sa + (1 << sh) - 1) / (1 << sh));
                return (sa + 256) % 256;
            end
            2: return (b >= 8) ? 0 : a / (1 << sh);
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_data      = v;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic gap();
        repeat (1 + $urandom_range(0, 2)) tick();
    endtask

    task automatic finish_tx();
        tx_done_tick = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        tx_done_tick = 1'b0;
        tick();
    endtask

    // One full transaction; skip_a means operand A was already delivered,
    // extra injects a stray byte while the transmission is outstanding.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input bit skip_a, input bit extra);
        int exp;
        int base;
        exp  = alu_ref(int'(a), int'(b), int'(op));
        base = pulses;
        if (!skip_a) begin
            send_byte(a);
            gap();
        end
        send_byte(b);
        gap();
        send_byte(op);
        check("tx_start_before", int'(tx_start), 0);
        tick();
        check("tx_start_rise", int'(tx_start), 1);
        check("tx_data", int'(tx_data), exp);
        check("result", int'(result), exp);
        tick();
        check("tx_start_fall", int'(tx_start), 0);
        if (extra) begin
            send_byte(8'h77);
            gap();
        end
        finish_tx();
        check("pulse_count", pulses - base, 1);
        check("result_hold", int'(result), exp);
    endtask

    logic [7:0] legal_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    initial begin
        int base;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;

        #1 reset = 1'b1;
        #1;
        check("reset_tx_start", int'(tx_start), 0);
        check("reset_tx_data", int'(tx_data), 0);
        check("reset_result", int'(result), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // Directed cases
        do_op(8'h05, 8'h03, 8'h20, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 8'h22, 1'b0, 1'b0);
        do_op(8'h80, 8'h02, 8'h03, 1'b0, 1'b0);
        do_op(8'h80, 8'h02, 8'h02, 1'b0, 1'b0);
        do_op(8'h80, 8'h09, 8'h02, 1'b0, 1'b0);
        do_op(8'h80, 8'h09, 8'h03, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 8'h24, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 8'h25, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 8'h26, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 8'h27, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 8'h3F, 1'b0, 1'b0);
        do_op(8'h12, 8'h34, 8'hE0, 1'b0, 1'b0);

        // Held rx flag: only the first byte counts as operand A
        base         = pulses;
        rx_data      = 8'h11;
        rx_done_tick = 1'b1;
        tick();
        repeat (99) begin
            rx_data = 8'($urandom);
            tick();
        end
        check("held_no_pulse", pulses - base, 0);
        rx_done_tick = 1'b0;
        tick();
        do_op(8'h11, 8'h22, 8'h20, 1'b1, 1'b0);

        // Stray byte during transmission is dropped
        do_op(8'h40, 8'h07, 8'h22, 1'b0, 1'b1);
        do_op(8'h01, 8'h02, 8'h20, 1'b0, 1'b0);

        // Asynchronous reset mid-sequence
        send_byte(8'h40);
        gap();
        send_byte(8'h41);
        #3 reset = 1'b1;
        #1;
        check("mid_reset_tx_start", int'(tx_start), 0);
        check("mid_reset_tx_data", int'(tx_data), 0);
        check("mid_reset_result", int'(result), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        do_op(8'h01, 8'h01, 8'h20, 1'b0, 1'b0);

        // Randomized operand sets
        for (int i = 0; i < 25; i++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 7)];
            do_op(ra, rb, rop, 1'b0, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
